// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Counts rising edges of an asynchronous input over a fixed window
//            of GATE_CYCLES f_clk cycles and reports the count as 4 BCD digits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   GATE_CYCLES : f_clk cycles per measurement window (legal 2..131071)
// Ports
//   f_clk    in   1  system clock, all logic on rising edge
//   reset    in   1  synchronous active-high reset
//   sig_in   in   1  signal under measurement, asynchronous to f_clk
//   bcd_out  out 16  last window's rising-edge count, [15:12] thousands..[3:0] units
//   valid    out  1  one-cycle pulse when bcd_out/overflow are updated
//   overflow out  1  last window contained more than 9999 edges
//   gate     out  1  high while a trusted measurement window is open
// Configuration
//   FREQ_METER_SAT_EN : when defined the accumulator saturates at 9999;
//                       otherwise it wraps 9999 -> 0000. Overflow is flagged
//                       in both builds.
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 100000
) (
  input  logic        f_clk,
  input  logic        reset,
  input  logic        sig_in,
  output logic [15:0] bcd_out,
  output logic        valid,
  output logic        overflow,
  output logic        gate
);

  localparam int            TW       = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] TERMINAL = TW'(GATE_CYCLES - 1);
  localparam logic [15:0]   BCD_MAX  = 16'h9999;

  // The first window after reset runs with untrusted synchronizer contents,
  // so its result is dropped; every later window is reported.
  typedef enum logic [0:0] {
    ST_DISCARD = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   acc_q, acc_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;

  logic          rise;
  logic          terminal;
  logic          at_max;
  logic [15:0]   acc_inc;
  logic [15:0]   acc_step;
  logic          pend_step;

  // BCD +1 with ripple carry; 9999 wraps naturally to 0000.
  function automatic logic [15:0] bcd_incr(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign rise     = sync2_q & ~sync3_q;
  assign terminal = (timer_q == TERMINAL);
  assign at_max   = (acc_q == BCD_MAX);
  assign acc_inc  = bcd_incr(acc_q);

  // Accumulator update for this cycle, including a rise seen in the
  // terminal cycle so it lands in the closing window.
  always_comb begin
    acc_step  = acc_q;
    pend_step = ovf_pend_q;
    if (rise) begin
      if (at_max) begin
        pend_step = 1'b1;
      end
`ifdef FREQ_METER_SAT_EN
      if (!at_max) begin
        acc_step = acc_inc;
      end
`else
      acc_step = acc_inc;
`endif
    end
  end

  // Next-state / window-close logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    acc_d      = acc_step;
    ovf_pend_d = pend_step;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    if (terminal) begin
      timer_d    = '0;
      acc_d      = '0;
      ovf_pend_d = 1'b0;
      state_d    = ST_MEASURE;
      if (state_q == ST_MEASURE) begin
        bcd_d   = acc_step;
        ovf_d   = pend_step;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge f_clk) begin
    if (reset) begin
      state_q    <= ST_DISCARD;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      timer_q    <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sig_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      timer_q    <= timer_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  assign gate     = (state_q == ST_MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Self-checking bench for freq_meter. Instance A (GATE_CYCLES=100)
//            covers periodic input, terminal-cycle rise, mid-window reset and
//            constant input; instance B (GATE_CYCLES=20000) covers overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int GA = 100;
  localparam int GB = 20000;

`ifdef FREQ_METER_SAT_EN
  localparam logic [15:0] EXP_B = 16'h9999;
`else
  localparam logic [15:0] EXP_B = 16'h0000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, sig_a, rst_b, sig_b;
  logic [15:0] bcd_a, bcd_b;
  logic        valid_a, valid_b, ovf_a, ovf_b, gate_a, gate_b;
  logic        lvl, sq_en, sq;
  int          sq_cnt;

  int asserts = 0;
  int fails   = 0;

  logic [16:0] exp_a[$];
  logic [16:0] exp_b[$];

  assign sig_a = sq_en ? sq : lvl;

  freq_meter #(.GATE_CYCLES(GA)) dut_a (
    .f_clk(clk), .reset(rst_a), .sig_in(sig_a),
    .bcd_out(bcd_a), .valid(valid_a), .overflow(ovf_a), .gate(gate_a)
  );

  freq_meter #(.GATE_CYCLES(GB)) dut_b (
    .f_clk(clk), .reset(rst_b), .sig_in(sig_b),
    .bcd_out(bcd_b), .valid(valid_b), .overflow(ovf_b), .gate(gate_b)
  );

  // Period-10 square wave for instance A.
  initial begin
    sq     = 1'b0;
    sq_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (sq_cnt == 4) begin
        sq_cnt = 0;
        sq     = ~sq;
      end else begin
        sq_cnt++;
      end
    end
  end

  // Instance B: reset briefly, then toggle its input every cycle.
  initial begin
    rst_b = 1'b1;
    sig_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      sig_b = ~sig_b;
    end
  end

  // Waits (bounded) for valid_a, sampling on falling edges. n is the number
  // of falling edges consumed; stable drops if outputs moved without valid.
  task automatic wait_valid_a(input int limit, output int n, output bit got, output bit stable);
    logic [16:0] ref_v;
    n = 0; got = 1'b0; stable = 1'b1; ref_v = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      n++;
      if (valid_a === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (i == 0) ref_v = {ovf_a, bcd_a};
      else if ({ovf_a, bcd_a} !== ref_v) stable = 1'b0;
    end
  endtask

  task automatic do_reset_a();
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    asserts++;
    if (bcd_a !== 16'h0000) begin fails++; $display("FAIL reset_bcd: got %h required 0000", bcd_a); end
    asserts++;
    if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", valid_a); end
    asserts++;
    if (ovf_a !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b required 0", ovf_a); end
    asserts++;
    if (gate_a !== 1'b0) begin fails++; $display("FAIL reset_gate: got %b required 0", gate_a); end
  endtask

  task automatic test_period10();
    int n; bit got, stable; logic [16:0] e;
    lvl = 1'b0; sq_en = 1'b1;
    do_reset_a();
    for (int w = 0; w < 3; w++) exp_a.push_back({1'b0, 16'h0010});
    for (int w = 0; w < 3; w++) begin
      wait_valid_a((w == 0) ? 260 : 160, n, got, stable);
      asserts++;
      if (!got || n != ((w == 0) ? 201 : 99)) begin
        fails++; $display("FAIL p10_latency[%0d]: got %0d cycles (seen=%0b) required %0d", w, n, got, (w == 0) ? 201 : 99);
      end
      asserts++;
      if (!stable) begin fails++; $display("FAIL p10_hold[%0d]: outputs changed between valid pulses, required constant", w); end
      if (got) begin
        e = exp_a.pop_front();
        asserts++;
        if ({ovf_a, bcd_a} !== e) begin
          fails++; $display("FAIL p10_result[%0d]: got ovf=%b bcd=%h required ovf=%b bcd=%h", w, ovf_a, bcd_a, e[16], e[15:0]);
        end
        asserts++;
        if (gate_a !== 1'b1) begin fails++; $display("FAIL p10_gate[%0d]: got %b required 1", w, gate_a); end
        @(negedge clk);
        asserts++;
        if (valid_a !== 1'b0) begin fails++; $display("FAIL p10_pulse_width[%0d]: got %b required 0", w, valid_a); end
      end
    end
    exp_a.delete();
  endtask

  task automatic test_terminal_rise();
    int n; bit got, stable; logic [16:0] e;
    lvl = 1'b0; sq_en = 1'b0;
    do_reset_a();
    // Raised in cycle 197 -> rise seen in cycle 199, the terminal cycle of
    // the first reported window.
    repeat (197) @(posedge clk);
    #1 lvl = 1'b1;
    exp_a.push_back({1'b0, 16'h0001});
    exp_a.push_back({1'b0, 16'h0000});
    for (int w = 0; w < 2; w++) begin
      wait_valid_a((w == 0) ? 20 : 160, n, got, stable);
      asserts++;
      if (!got || n != ((w == 0) ? 4 : 99)) begin
        fails++; $display("FAIL term_latency[%0d]: got %0d cycles (seen=%0b) required %0d", w, n, got, (w == 0) ? 4 : 99);
      end
      if (got) begin
        e = exp_a.pop_front();
        asserts++;
        if ({ovf_a, bcd_a} !== e) begin
          fails++; $display("FAIL term_result[%0d]: got ovf=%b bcd=%h required ovf=%b bcd=%h", w, ovf_a, bcd_a, e[16], e[15:0]);
        end
        @(negedge clk);
      end
    end
    exp_a.delete();
  endtask

  task automatic test_reset_midwindow();
    int n; bit got, stable; logic [16:0] e;
    lvl = 1'b0; sq_en = 1'b1;
    do_reset_a();
    exp_a.push_back({1'b0, 16'h0010});
    wait_valid_a(260, n, got, stable);
    asserts++;
    if (!got || n != 201) begin fails++; $display("FAIL mid_pre_latency: got %0d cycles (seen=%0b) required 201", n, got); end
    if (got) begin
      e = exp_a.pop_front();
      asserts++;
      if ({ovf_a, bcd_a} !== e) begin
        fails++; $display("FAIL mid_pre_result: got ovf=%b bcd=%h required ovf=%b bcd=%h", ovf_a, bcd_a, e[16], e[15:0]);
      end
    end
    // From cycle 200, move to cycle 250 (timer=50) and pulse reset.
    repeat (50) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    asserts++;
    if (bcd_a !== 16'h0000) begin fails++; $display("FAIL mid_bcd_cleared: got %h required 0000", bcd_a); end
    asserts++;
    if (gate_a !== 1'b0) begin fails++; $display("FAIL mid_gate_low: got %b required 0", gate_a); end
    asserts++;
    if (valid_a !== 1'b0) begin fails++; $display("FAIL mid_valid_low: got %b required 0", valid_a); end
    exp_a.push_back({1'b0, 16'h0010});
    wait_valid_a(260, n, got, stable);
    asserts++;
    if (!got || n != 200) begin fails++; $display("FAIL mid_post_latency: got %0d cycles (seen=%0b) required 200", n, got); end
    if (got) begin
      e = exp_a.pop_front();
      asserts++;
      if ({ovf_a, bcd_a} !== e) begin
        fails++; $display("FAIL mid_post_result: got ovf=%b bcd=%h required ovf=%b bcd=%h", ovf_a, bcd_a, e[16], e[15:0]);
      end
      @(negedge clk);
    end
    exp_a.delete();
  endtask

  task automatic test_constant();
    int n; bit got, stable; logic [16:0] e;
    lvl = 1'b1; sq_en = 1'b0;
    do_reset_a();
    for (int w = 0; w < 4; w++) exp_a.push_back({1'b0, 16'h0000});
    for (int w = 0; w < 4; w++) begin
      wait_valid_a((w == 0) ? 260 : 160, n, got, stable);
      asserts++;
      if (!got || n != ((w == 0) ? 201 : 99)) begin
        fails++; $display("FAIL const_latency[%0d]: got %0d cycles (seen=%0b) required %0d", w, n, got, (w == 0) ? 201 : 99);
      end
      if (got) begin
        e = exp_a.pop_front();
        asserts++;
        if ({ovf_a, bcd_a} !== e) begin
          fails++; $display("FAIL const_result[%0d]: got ovf=%b bcd=%h required ovf=%b bcd=%h", w, ovf_a, bcd_a, e[16], e[15:0]);
        end
        @(negedge clk);
      end
      if (w == 1) lvl = 1'b0;
    end
    exp_a.delete();
  endtask

  task automatic test_overflow();
    bit got; logic [16:0] e;
    got = 1'b0;
    exp_b.push_back({1'b1, EXP_B});
    for (int i = 0; i < 45000; i++) begin
      @(negedge clk);
      if (valid_b === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    asserts++;
    if (!got) begin
      fails++; $display("FAIL ovf_timeout: got no valid within 45000 cycles required one");
    end else begin
      e = exp_b.pop_front();
      asserts++;
      if ({ovf_b, bcd_b} !== e) begin
        fails++; $display("FAIL ovf_result: got ovf=%b bcd=%h required ovf=%b bcd=%h", ovf_b, bcd_b, e[16], e[15:0]);
      end
      asserts++;
      if (gate_b !== 1'b1) begin fails++; $display("FAIL ovf_gate: got %b required 1", gate_b); end
    end
    exp_b.delete();
  endtask

  initial begin
    rst_a = 1'b1;
    lvl   = 1'b0;
    sq_en = 1'b0;
    test_reset();
    test_period10();
    test_terminal_rise();
    test_reset_midwindow();
    test_constant();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100000, meaning f_clk cycles per measurement window (1 s at 100 kHz); legal range 2..131071.
REQ-002 SHALL have port f_clk  input  1  system clock, 100 kHz nominal, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising f_clk.
REQ-004 SHALL have port sig_in  input  1  signal under measurement, asynchronous to f_clk.
REQ-005 SHALL have port bcd_out  output  16  last completed window's rising-edge count, 4 BCD digits, [15:12] thousands .. [3:0] units.
REQ-006 SHALL have port valid  output  1  one-cycle pulse marking a new bcd_out value.
REQ-007 SHALL have port overflow  output  1  last completed window contained more than 9999 edges.
REQ-008 SHALL have port gate  output  1  high while a measurement window is open.

Function
REQ-009 SHALL pass sig_in through a two-flop synchronizer, then a third flop for edge detection; rise = sync2 & ~sync3.
REQ-010 SHALL report a sig_in rising edge as rise on the third rising f_clk edge after sig_in is stably high.
REQ-011 SHALL use a binary gate timer running 0..GATE_CYCLES-1, wrapping to 0, with no dead cycles between windows.
REQ-012 SHALL hold a 4-digit BCD accumulator, incremented by 1 per rise cycle, each digit rolling 9->0 with carry into the next.
REQ-013 SHALL count a rise occurring in the timer's terminal cycle (GATE_CYCLES-1) in the closing window.
REQ-014 SHALL, on the edge ending the terminal cycle, load bcd_out with the final accumulator value, clear the accumulator to 0000, and assert valid for exactly one cycle.
REQ-015 SHALL hold bcd_out and overflow constant between valid pulses.
REQ-016 SHALL set an internal overflow-pending flag when an increment occurs at 9999, transfer it to overflow at window end, and clear it for the next window.
REQ-017 SHALL drive gate low only during the first window after reset; the first window's result is discarded (no valid), because the synchronizer contents are not trusted; gate is high in all subsequent windows.
REQ-018 SHALL keep the accumulator unchanged when sig_in is constant; a constant input yields bcd_out=0000, overflow=0.
REQ-019 SHALL produce no X on any output once reset has been sampled high.

Reset
REQ-020 SHALL, on reset sampled high, clear the synchronizer flops, timer, accumulator and overflow-pending flag, and drive bcd_out=0000, valid=0, overflow=0 and gate=0 on the following cycle.
REQ-021 SHALL abort a window in progress on reset mid-window; no valid is emitted for the aborted window.
REQ-022 SHALL restart with timer=0 on the first cycle after reset deasserts; that window is the discarded window of REQ-017.

Configuration
REQ-023 SHALL support macro FREQ_METER_SAT_EN.
- Defined: the accumulator saturates at 9999; further rises are ignored apart from setting overflow-pending.
- Undefined: the accumulator wraps 9999->0000 and continues counting; overflow-pending is still set.
REQ-024 SHALL leave ports and all other timing identical in both configurations.

Verification
REQ-025 GATE_CYCLES=100, sig_in period 10 cycles -> from the second window on, valid pulses every 100 cycles, bcd_out=0x0010, overflow=0.
REQ-026 GATE_CYCLES=20000, sig_in toggled every cycle -> 10000 rises per window; with FREQ_METER_SAT_EN bcd_out=0x9999, overflow=1; without it bcd_out=0x0000, overflow=1.
REQ-027 GATE_CYCLES=100, single rise timed into timer cycle 99 -> closing window reports 0x0001 and the next window reports 0x0000.
REQ-028 Reset pulsed at timer=50 of a counting window -> no valid for that window, bcd_out=0000 and gate=0 next cycle, first valid appears 200 cycles after reset deasserts.
REQ-029 sig_in held at 1 and then at 0 across several windows -> bcd_out=0x0000 and overflow=0 each window, and valid is still periodic.
